// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stage registers.
//   - memToReg writeback-source encodings
//   - default datapath widths used as parameter defaults by the stage registers
// ---------------------------------------------------------------------------
package pipe_pkg;

   // Writeback source select carried in memToReg.
   localparam logic [1:0] MTR_ALU  = 2'd0;  // ALU result
   localparam logic [1:0] MTR_MEM  = 2'd1;  // load data from data memory
   localparam logic [1:0] MTR_PCPP = 2'd2;  // PC+4 (link)
   localparam logic [1:0] MTR_RSVD = 2'd3;  // reserved, behaves like MTR_ALU

   // Default widths.
   localparam int DEFAULT_DATA_W     = 32;
   localparam int DEFAULT_REG_ADDR_W = 4;
   localparam int DEFAULT_CNT_W      = 16;

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter for pipeline-register statistics. Counts on the
// falling edge of the stage clock, like the pipeline registers it serves.
//
// Ports:
//   clock_i  in   stage clock (state changes on the falling edge)
//   clr_i    in   synchronous clear, has priority over inc_i
//   inc_i    in   increment request for this edge
//   count_o  out  current count, sticks at 2^CNT_W-1
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clock_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Hold at the maximum instead of wrapping back to zero.
   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(negedge clock_i) begin
      if (clr_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule : sat_counter

// File: rtl/mem_wb_pipe.sv
// ---------------------------------------------------------------------------
// mem_wb_pipe
// MEM/WB pipeline register between the data-memory stage and register-file
// writeback. All state changes on the falling edge of clock. Per edge the
// update priority is reset > flush > stall > load.
//
// Ports (inputs, sampled on the falling edge):
//   clock, reset (sync, active-high), stall (hold), flush (insert bubble),
//   valid_in, DataOutDataMemory_in, memToReg_in, ALUResult_in,
//   registerFileWrite_in, regWrite_in, pcpp_in
// Ports (outputs):
//   valid, DataOutDataMemory, memToReg, ALUResult, registerFileWrite,
//   regWrite, pcpp               registered stage contents
//   wbData                       writeback value selected by memToReg
//   fwdValid, fwdReg             view for the forwarding/hazard unit
//   stallCount, bubbleCount      saturating statistics counters
// ---------------------------------------------------------------------------
module mem_wb_pipe
   import pipe_pkg::*;
#(
   parameter int DATA_W     = DEFAULT_DATA_W,
   parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
   parameter int CNT_W      = DEFAULT_CNT_W
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  valid_in,
   input  logic [DATA_W-1:0]     DataOutDataMemory_in,
   input  logic [1:0]            memToReg_in,
   input  logic [DATA_W-1:0]     ALUResult_in,
   input  logic [REG_ADDR_W-1:0] registerFileWrite_in,
   input  logic                  regWrite_in,
   input  logic [DATA_W-1:0]     pcpp_in,
   output logic                  valid,
   output logic [DATA_W-1:0]     DataOutDataMemory,
   output logic [1:0]            memToReg,
   output logic [DATA_W-1:0]     ALUResult,
   output logic [REG_ADDR_W-1:0] registerFileWrite,
   output logic                  regWrite,
   output logic [DATA_W-1:0]     pcpp,
   output logic [DATA_W-1:0]     wbData,
   output logic                  fwdValid,
   output logic [REG_ADDR_W-1:0] fwdReg,
   output logic [CNT_W-1:0]      stallCount,
   output logic [CNT_W-1:0]      bubbleCount
);

   // ------------------------------------------------------------------------
   // Stage registers
   // ------------------------------------------------------------------------
   logic                  valid_q,    valid_d;
   logic [DATA_W-1:0]     dmem_q,     dmem_d;
   logic [1:0]            mtr_q,      mtr_d;
   logic [DATA_W-1:0]     alu_q,      alu_d;
   logic [REG_ADDR_W-1:0] rfw_q,      rfw_d;
   logic                  rw_q,       rw_d;
   logic [DATA_W-1:0]     pcpp_q,     pcpp_d;

   // Next-state selection. Reset is handled in the register process so it
   // overrides everything computed here.
   always_comb begin
      valid_d = valid_q;
      dmem_d  = dmem_q;
      mtr_d   = mtr_q;
      alu_d   = alu_q;
      rfw_d   = rfw_q;
      rw_d    = rw_q;
      pcpp_d  = pcpp_q;
      if (flush) begin
         // Bubble: only the fields that could cause a write or a forward are
         // cleared; the datapath fields keep their old contents.
         valid_d = 1'b0;
         rw_d    = 1'b0;
         rfw_d   = '0;
      end else if (!stall) begin
         valid_d = valid_in;
         dmem_d  = DataOutDataMemory_in;
         mtr_d   = memToReg_in;
         alu_d   = ALUResult_in;
         rfw_d   = registerFileWrite_in;
         // An invalid instruction must never write the register file.
         rw_d    = regWrite_in & valid_in;
         pcpp_d  = pcpp_in;
      end
   end

   always_ff @(negedge clock) begin
      if (reset) begin
         valid_q <= 1'b0;
         dmem_q  <= '0;
         mtr_q   <= MTR_ALU;
         alu_q   <= '0;
         rfw_q   <= '0;
         rw_q    <= 1'b0;
         pcpp_q  <= '0;
      end else begin
         valid_q <= valid_d;
         dmem_q  <= dmem_d;
         mtr_q   <= mtr_d;
         alu_q   <= alu_d;
         rfw_q   <= rfw_d;
         rw_q    <= rw_d;
         pcpp_q  <= pcpp_d;
      end
   end

   assign valid             = valid_q;
   assign DataOutDataMemory = dmem_q;
   assign memToReg          = mtr_q;
   assign ALUResult         = alu_q;
   assign registerFileWrite = rfw_q;
   assign regWrite          = rw_q;
   assign pcpp              = pcpp_q;

   // ------------------------------------------------------------------------
   // Writeback mux and forwarding view
   // ------------------------------------------------------------------------
   always_comb begin
      wbData = '0;
      if (valid_q) begin
         case (mtr_q)
            MTR_MEM:  wbData = dmem_q;
            MTR_PCPP: wbData = pcpp_q;
            default:  wbData = alu_q;  // MTR_ALU and reserved MTR_RSVD
         endcase
      end
   end

   assign fwdValid = rw_q & valid_q;
   assign fwdReg   = rfw_q;

   // ------------------------------------------------------------------------
   // Statistics
   // ------------------------------------------------------------------------
   // A stall only counts when it actually held the stage (flush overrides).
   // A bubble is loaded either by flush or by a normal load of an invalid
   // instruction. The counters' own clear covers the reset edge.
   logic stall_inc;
   logic bubble_inc;

   assign stall_inc  = stall & ~flush;
   assign bubble_inc = flush | (~stall & ~valid_in);

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clock_i (clock),
      .clr_i   (reset),
      .inc_i   (stall_inc),
      .count_o (stallCount)
   );

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_bubble_cnt (
      .clock_i (clock),
      .clr_i   (reset),
      .inc_i   (bubble_inc),
      .count_o (bubbleCount)
   );

endmodule : mem_wb_pipe

// File: tb/tb_mem_wb_pipe.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_pipe
// Directed bench for mem_wb_pipe. Inputs change on the rising edge, the DUT
// updates on the falling edge, and outputs are sampled 2 time units after
// the falling edge. A second instance with CNT_W=2 shares the stimulus and
// exposes counter saturation.
// ---------------------------------------------------------------------------
module tb_mem_wb_pipe;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        valid_in = 1'b0;
   logic [31:0] dmem_in = '0;
   logic [1:0]  mtr_in = '0;
   logic [31:0] alu_in = '0;
   logic [3:0]  rfw_in = '0;
   logic        rw_in = 1'b0;
   logic [31:0] pcpp_in = '0;

   logic        valid, regWrite, fwdValid;
   logic [31:0] DataOutDataMemory, ALUResult, pcpp, wbData;
   logic [1:0]  memToReg;
   logic [3:0]  registerFileWrite, fwdReg;
   logic [15:0] stallCount, bubbleCount;

   logic        s_valid, s_regWrite, s_fwdValid;
   logic [31:0] s_dmem, s_alu, s_pcpp, s_wbData;
   logic [1:0]  s_memToReg;
   logic [3:0]  s_rfw, s_fwdReg;
   logic [1:0]  s_stallCount, s_bubbleCount;

   mem_wb_pipe dut (
      .clock                (clock),
      .reset                (reset),
      .stall                (stall),
      .flush                (flush),
      .valid_in             (valid_in),
      .DataOutDataMemory_in (dmem_in),
      .memToReg_in          (mtr_in),
      .ALUResult_in         (alu_in),
      .registerFileWrite_in (rfw_in),
      .regWrite_in          (rw_in),
      .pcpp_in              (pcpp_in),
      .valid                (valid),
      .DataOutDataMemory    (DataOutDataMemory),
      .memToReg             (memToReg),
      .ALUResult            (ALUResult),
      .registerFileWrite    (registerFileWrite),
      .regWrite             (regWrite),
      .pcpp                 (pcpp),
      .wbData               (wbData),
      .fwdValid             (fwdValid),
      .fwdReg               (fwdReg),
      .stallCount           (stallCount),
      .bubbleCount          (bubbleCount)
   );

   mem_wb_pipe #(.CNT_W(2)) dut_sat (
      .clock                (clock),
      .reset                (reset),
      .stall                (stall),
      .flush                (flush),
      .valid_in             (valid_in),
      .DataOutDataMemory_in (dmem_in),
      .memToReg_in          (mtr_in),
      .ALUResult_in         (alu_in),
      .registerFileWrite_in (rfw_in),
      .regWrite_in          (rw_in),
      .pcpp_in              (pcpp_in),
      .valid                (s_valid),
      .DataOutDataMemory    (s_dmem),
      .memToReg             (s_memToReg),
      .ALUResult            (s_alu),
      .registerFileWrite    (s_rfw),
      .regWrite             (s_regWrite),
      .pcpp                 (s_pcpp),
      .wbData               (s_wbData),
      .fwdValid             (s_fwdValid),
      .fwdReg               (s_fwdReg),
      .stallCount           (s_stallCount),
      .bubbleCount          (s_bubbleCount)
   );

   // ---------------- scoreboard ----------------
   typedef struct {
      logic        valid;
      logic [31:0] dm;
      logic [1:0]  mtr;
      logic [31:0] alu;
      logic [3:0]  rfw;
      logic        rw;
      logic [31:0] pc;
      logic [31:0] wb;
      logic        fwdv;
      logic [3:0]  fwdr;
      logic [15:0] sc;
      logic [15:0] bc;
      logic [1:0]  ssc;
      logic [1:0]  sbc;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp_cur;
   int   checks   = 0;
   int   failures = 0;
   int   step_no  = 0;

   task automatic chk(input string name, input int stp, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s step=%0d actual=0x%08h required=0x%08h", name, stp, act, req);
      end
   endtask

   // Monitor: one expected entry per falling edge that followed a push.
   initial begin : monitor
      exp_t e;
      int   n = 0;
      forever begin
         @(negedge clock);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n++;
            chk("valid",       n, 32'(valid),             32'(e.valid));
            chk("dmem",        n, DataOutDataMemory,      e.dm);
            chk("memToReg",    n, 32'(memToReg),          32'(e.mtr));
            chk("alu",         n, ALUResult,              e.alu);
            chk("rfw",         n, 32'(registerFileWrite), 32'(e.rfw));
            chk("regWrite",    n, 32'(regWrite),          32'(e.rw));
            chk("pcpp",        n, pcpp,                   e.pc);
            chk("wbData",      n, wbData,                 e.wb);
            chk("fwdValid",    n, 32'(fwdValid),          32'(e.fwdv));
            chk("fwdReg",      n, 32'(fwdReg),            32'(e.fwdr));
            chk("stallCount",  n, 32'(stallCount),        32'(e.sc));
            chk("bubbleCount", n, 32'(bubbleCount),       32'(e.bc));
            chk("satStall",    n, 32'(s_stallCount),      32'(e.ssc));
            chk("satBubble",   n, 32'(s_bubbleCount),     32'(e.sbc));
            chk("satWb",       n, s_wbData,               e.wb);
         end
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic rst, input logic st, input logic fl,
                        input logic v, input logic [1:0] mtr,
                        input logic [31:0] dm, input logic [31:0] alu,
                        input logic [31:0] pc, input logic [3:0] rfw,
                        input logic rw);
      @(posedge clock);
      reset    = rst;
      stall    = st;
      flush    = fl;
      valid_in = v;
      mtr_in   = mtr;
      dmem_in  = dm;
      alu_in   = alu;
      pcpp_in  = pc;
      rfw_in   = rfw;
      rw_in    = rw;
      step_no++;
      exp_q.push_back(exp_cur);
   endtask

   task automatic clear_exp();
      exp_cur = '{valid: 1'b0, dm: '0, mtr: '0, alu: '0, rfw: '0, rw: 1'b0,
                  pc: '0, wb: '0, fwdv: 1'b0, fwdr: '0, sc: '0, bc: '0,
                  ssc: '0, sbc: '0};
   endtask

   initial begin : stimulus
      logic [1:0] sat_seq [5];
      sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      // Reset with random inputs for two edges: everything zero.
      clear_exp();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
               $urandom, $urandom, 4'($urandom_range(0, 15)), 1'b1);
      end

      // First real load, ALU writeback.
      exp_cur.valid = 1'b1; exp_cur.alu = 32'h0000_1234; exp_cur.rfw = 4'd5;
      exp_cur.rw = 1'b1; exp_cur.wb = 32'h0000_1234; exp_cur.fwdv = 1'b1;
      exp_cur.fwdr = 4'd5;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0000_1234, 32'h0, 4'd5, 1'b1);

      // Writeback select: memory, PC+4, reserved.
      exp_cur.dm = 32'hDEAD_BEEF; exp_cur.pc = 32'h44; exp_cur.alu = 32'h10;
      exp_cur.rfw = 4'd3; exp_cur.fwdr = 4'd3;
      exp_cur.mtr = 2'd1; exp_cur.wb = 32'hDEAD_BEEF;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 32'hDEAD_BEEF, 32'h10, 32'h44, 4'd3, 1'b1);
      exp_cur.mtr = 2'd2; exp_cur.wb = 32'h44;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'hDEAD_BEEF, 32'h10, 32'h44, 4'd3, 1'b1);
      exp_cur.mtr = 2'd3; exp_cur.wb = 32'h10;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 32'hDEAD_BEEF, 32'h10, 32'h44, 4'd3, 1'b1);

      // Load ALUResult=0xA, then stall three edges with different inputs.
      exp_cur.mtr = 2'd0; exp_cur.alu = 32'hA; exp_cur.wb = 32'hA;
      exp_cur.rfw = 4'd2; exp_cur.fwdr = 4'd2;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'hDEAD_BEEF, 32'hA, 32'h44, 4'd2, 1'b1);
      for (int i = 1; i <= 3; i++) begin
         exp_cur.sc = 16'(i); exp_cur.ssc = 2'(i);
         drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 32'h0, 32'hB, 32'h50, 4'd9, 1'b1);
      end
      // Release: 0xB arrives.
      exp_cur.alu = 32'hB; exp_cur.wb = 32'hB;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'hDEAD_BEEF, 32'hB, 32'h44, 4'd2, 1'b1);

      // Flush together with stall: bubble, datapath fields held.
      exp_cur.valid = 1'b0; exp_cur.rw = 1'b0; exp_cur.rfw = 4'd0;
      exp_cur.fwdr = 4'd0; exp_cur.fwdv = 1'b0; exp_cur.wb = 32'h0;
      exp_cur.bc = 16'd1; exp_cur.sbc = 2'd1;
      drive(1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 32'h0, 32'hC, 32'h60, 4'd6, 1'b1);

      // Invalid load with regWrite_in=1: captured but never writes.
      exp_cur.rfw = 4'd7; exp_cur.fwdr = 4'd7; exp_cur.alu = 32'hD;
      exp_cur.dm = 32'h1111; exp_cur.pc = 32'h48;
      exp_cur.bc = 16'd2; exp_cur.sbc = 2'd2;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h1111, 32'hD, 32'h48, 4'd7, 1'b1);

      // Valid instruction without a register write.
      exp_cur.valid = 1'b1; exp_cur.rfw = 4'd1; exp_cur.fwdr = 4'd1;
      exp_cur.alu = 32'hE; exp_cur.dm = 32'h2222; exp_cur.pc = 32'h4C;
      exp_cur.wb = 32'hE;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h2222, 32'hE, 32'h4C, 4'd1, 1'b0);

      // Reset mid-run with stall high: everything cleared.
      clear_exp();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 32'h3333, 32'hF, 32'h70, 4'd4, 1'b1);

      // Five stalls: 16-bit counter reaches 5, 2-bit counter sticks at 3.
      for (int i = 0; i < 5; i++) begin
         exp_cur.sc = 16'(i + 1); exp_cur.ssc = sat_seq[i];
         drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 32'h3333, 32'hF, 32'h70, 4'd4, 1'b1);
      end

      // Reset with stall and flush high: counters cleared on that edge.
      clear_exp();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 32'h3333, 32'hF, 32'h70, 4'd4, 1'b1);

      // Plain flush after reset.
      exp_cur.bc = 16'd1; exp_cur.sbc = 2'd1;
      drive(1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 32'h4444, 32'h12, 32'h74, 4'd8, 1'b1);

      // Let the monitor consume the last entry, then confirm nothing is left.
      @(posedge clock);
      reset = 1'b0; stall = 1'b1; flush = 1'b0;
      repeat (3) @(negedge clock);
      #3;
      chk("drain", step_no, 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #50000;
      $display("FAIL watchdog step=%0d actual=timeout required=finish", step_no);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_mem_wb_pipe
